// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master.
// Sends an 8-byte command (start) or the single INIT byte 0x11 (init).
// Bytes go out LSB first. Each byte has its own SS-low window, and the
// windows are separated by a programmable SS-high gap. MISO bytes are
// collected in a shadow buffer and published on rx_data together with
// the one-cycle done pulse.
module spi_cmd_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic        init,
    input  logic [63:0] tx_cmd,
    output logic        busy,
    output logic        done,
    output logic [63:0] rx_data,
    output logic        SPI_SCK,
    output logic        SPI_SS,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP,
        FIN
    } state_t;

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  divCnt_q, divCnt_d;
    logic [3:0]  bitCnt_q, bitCnt_d;
    logic [2:0]  byteCnt_q, byteCnt_d;
    logic [2:0]  lastByte_q, lastByte_d;
    logic [15:0] gapCnt_q, gapCnt_d;
    logic [63:0] txBuf_q, txBuf_d;
    logic [63:0] rxShadow_q, rxShadow_d;
    logic [63:0] rxData_q, rxData_d;
    logic        sck_q, sck_d;
    logic        ss_q, ss_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        divEnd;

    // The divider reaching its last count ends every SCK half-period and every
    // SETUP/HOLD phase.
    assign divEnd = (divCnt_q == DIV_LAST);

    // Next-state logic. Pin-level outputs are derived from the next state, so
    // that SCK, SS, busy and done all come straight from flops.
    always_comb begin
        state_d    = state_q;
        divCnt_d   = divCnt_q;
        bitCnt_d   = bitCnt_q;
        byteCnt_d  = byteCnt_q;
        lastByte_d = lastByte_q;
        gapCnt_d   = gapCnt_q;
        txBuf_d    = txBuf_q;
        rxShadow_d = rxShadow_q;
        rxData_d   = rxData_q;

        case (state_q)
            IDLE: begin
                if (init || start) begin
                    state_d    = SETUP;
                    divCnt_d   = 8'd0;
                    bitCnt_d   = 4'd0;
                    byteCnt_d  = 3'd0;
                    gapCnt_d   = 16'd0;
                    rxShadow_d = 64'd0;
                    if (init) begin
                        txBuf_d    = 64'h11;
                        lastByte_d = 3'd0;
                    end else begin
                        txBuf_d    = tx_cmd;
                        lastByte_d = 3'd7;
                    end
                end
            end
            SETUP: begin
                if (divEnd) begin
                    state_d  = SHIFT;
                    divCnt_d = 8'd0;
                    bitCnt_d = 4'd0;
                end else begin
                    divCnt_d = divCnt_q + 8'd1;
                end
            end
            SHIFT: begin
                if (divEnd) begin
                    divCnt_d = 8'd0;
                    if (bitCnt_q == 4'd15) begin
                        state_d  = HOLD;
                        bitCnt_d = 4'd0;
                    end else begin
                        bitCnt_d = bitCnt_q + 4'd1;
                        if (!bitCnt_q[0]) begin
                            txBuf_d = {1'b0, txBuf_q[63:1]};
                        end
                    end
                end else begin
                    divCnt_d = divCnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (divEnd) begin
                    divCnt_d = 8'd0;
                    if (byteCnt_q == lastByte_q) begin
                        state_d  = FIN;
                        rxData_d = rxShadow_q;
                    end else begin
                        state_d   = GAP;
                        gapCnt_d  = 16'd0;
                        byteCnt_d = byteCnt_q + 3'd1;
                    end
                end else begin
                    divCnt_d = divCnt_q + 8'd1;
                end
            end
            GAP: begin
                if (gapCnt_q == GAP_LAST) begin
                    state_d  = SETUP;
                    gapCnt_d = 16'd0;
                end else begin
                    gapCnt_d = gapCnt_q + 16'd1;
                end
            end
            FIN: begin
                state_d   = IDLE;
                byteCnt_d = 3'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sck_d  = (state_d == SHIFT) && !bitCnt_d[0];
        ss_d   = !(state_d inside {SETUP, SHIFT, HOLD});
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);

        if (sck_d && !sck_q) begin
            rxShadow_d[{byteCnt_q, bitCnt_d[3:1]}] = SPI_MISO;
        end
    end

    // State and datapath registers. Reset forces the idle bus immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            divCnt_q   <= 8'd0;
            bitCnt_q   <= 4'd0;
            byteCnt_q  <= 3'd0;
            lastByte_q <= 3'd0;
            gapCnt_q   <= 16'd0;
            txBuf_q    <= 64'd0;
            rxShadow_q <= 64'd0;
            rxData_q   <= 64'd0;
            sck_q      <= 1'b0;
            ss_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            divCnt_q   <= divCnt_d;
            bitCnt_q   <= bitCnt_d;
            byteCnt_q  <= byteCnt_d;
            lastByte_q <= lastByte_d;
            gapCnt_q   <= gapCnt_d;
            txBuf_q    <= txBuf_d;
            rxShadow_q <= rxShadow_d;
            rxData_q   <= rxData_d;
            sck_q      <= sck_d;
            ss_q       <= ss_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign SPI_SCK  = sck_q;
    assign SPI_SS   = ss_q;
    assign SPI_MOSI = txBuf_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rxData_q;

endmodule
